// File: rtl/acc_core_sequencer.sv
// Multi-cycle control sequencer for the accumulator core: fetch, decode, optional
// memory access, then accumulator or PC update, with a memory-ack watchdog.
module acc_core_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic [3:0] op_i,
    input  logic       acc_zero_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_write_o,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic       acc_write_o,
    output logic [1:0] acc_src_o,
    output logic [2:0] alu_op_o,
    output logic       instr_done_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_JUMP  = 4'b0001;
    localparam logic [3:0] OP_SAVE  = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_LOADI = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_UND   = 4'b1101;
    localparam logic [3:0] OP_BZ    = 4'b1111;

    localparam logic [1:0] SRC_MEM = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] SRC_ALU = 2'b10;
    localparam logic [1:0] SRC_SLL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_alu_op;
    logic is_mem_op;
    logic is_exec_op;
    logic wd_expire;
    logic waiting;

    // ALU ops are op[3]=1 except BZ and the undefined 1101
    assign is_alu_op  = op_i[3] && (op_i != OP_BZ) && (op_i != OP_UND);
    assign is_mem_op  = is_alu_op || (op_i == OP_LOAD) || (op_i == OP_SAVE);
    assign is_exec_op = (op_i == OP_NOP) || (op_i == OP_JUMP) || (op_i == OP_LOADI)
                     || (op_i == OP_SLL) || (op_i == OP_BZ);
    assign waiting    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack_i;
    assign wd_expire  = (TIMEOUT != 0) && (cnt_q == CNT_LAST) && waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and watchdog counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack_i)      state_d = S_DECODE;
                else if (wd_expire) state_d = S_FAULT;
            end
            S_DECODE: begin
                if (is_mem_op)       state_d = S_MEM;
                else if (is_exec_op) state_d = S_EXEC;
                else                 state_d = S_FAULT;
            end
            S_MEM: begin
                if (mem_ack_i)      state_d = run_i ? S_FETCH : S_IDLE;
                else if (wd_expire) state_d = S_FAULT;
            end
            S_EXEC: begin
                state_d = run_i ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (state_d != state_q)              cnt_d = '0;
        else if (waiting && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    // Strobes decoded from current state, opcode and handshake
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        addr_sel_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_inc_o     = 1'b0;
        pc_load_o    = 1'b0;
        acc_write_o  = 1'b0;
        acc_src_o    = SRC_MEM;
        alu_op_o     = 3'b000;
        instr_done_o = 1'b0;
        fault_o      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req_o  = 1'b1;
                ir_write_o = mem_ack_i;
                pc_inc_o   = mem_ack_i;
            end
            S_DECODE: begin
                alu_op_o = op_i[3] ? op_i[2:0] : 3'b000;
            end
            S_EXEC: begin
                alu_op_o     = op_i[3] ? op_i[2:0] : 3'b000;
                instr_done_o = 1'b1;
                if (op_i == OP_JUMP) pc_load_o = 1'b1;
                if (op_i == OP_BZ)   pc_load_o = acc_zero_i;
                if (op_i == OP_LOADI) begin
                    acc_write_o = 1'b1;
                    acc_src_o   = SRC_IMM;
                end
                if (op_i == OP_SLL) begin
                    acc_write_o = 1'b1;
                    acc_src_o   = SRC_SLL;
                end
            end
            S_MEM: begin
                mem_req_o    = 1'b1;
                addr_sel_o   = 1'b1;
                mem_we_o     = (op_i == OP_SAVE);
                alu_op_o     = op_i[3] ? op_i[2:0] : 3'b000;
                instr_done_o = mem_ack_i;
                if (mem_ack_i && op_i == OP_LOAD) begin
                    acc_write_o = 1'b1;
                    acc_src_o   = SRC_MEM;
                end
                if (mem_ack_i && is_alu_op) begin
                    acc_write_o = 1'b1;
                    acc_src_o   = SRC_ALU;
                end
            end
            S_FAULT: begin
                fault_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_acc_core_sequencer.sv
// Directed bench: stimulus pushes the hand-computed expected output vector for
// each cycle; a negedge monitor pops and compares it with the DUT outputs.
module tb_acc_core_sequencer;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       asel;
        logic       irw;
        logic       pinc;
        logic       pld;
        logic       accw;
        logic [1:0] src;
        logic [2:0] alu;
        logic       done;
        logic       flt;
    } exp_t;

    typedef struct {
        int   id;
        exp_t v;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] op = 4'b0000;
    logic       acc_zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, addr_sel, ir_write, pc_inc, pc_load, acc_write;
    logic [1:0] acc_src;
    logic [2:0] alu_op;
    logic       instr_done, fault;
    logic [2:0] state;

    sb_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  step_id  = 0;

    acc_core_sequencer #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .op_i         (op),
        .acc_zero_i   (acc_zero),
        .mem_ack_i    (mem_ack),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .addr_sel_o   (addr_sel),
        .ir_write_o   (ir_write),
        .pc_inc_o     (pc_inc),
        .pc_load_o    (pc_load),
        .acc_write_o  (acc_write),
        .acc_src_o    (acc_src),
        .alu_op_o     (alu_op),
        .instr_done_o (instr_done),
        .fault_o      (fault),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] st, input logic req, we, asel, irw, pinc,
                                input logic pld, accw, input logic [1:0] src,
                                input logic [2:0] alu, input logic done, flt);
        exp_t e;
        e = {st, req, we, asel, irw, pinc, pld, accw, src, alu, done, flt};
        return e;
    endfunction

    // Drive one cycle's inputs just after the clock edge and queue its expected outputs
    task automatic step(input logic r, input logic rn, input logic [3:0] o,
                        input logic z, input logic a, input exp_t e);
        sb_t s;
        rst_n    = r;
        run      = rn;
        op       = o;
        acc_zero = z;
        mem_ack  = a;
        s.id     = step_id;
        s.v      = e;
        exp_q.push_back(s);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_t  s;
            exp_t got;
            s   = exp_q.pop_front();
            got = {state, mem_req, mem_we, addr_sel, ir_write, pc_inc, pc_load, acc_write,
                   acc_src, alu_op, instr_done, fault};
            n_checks++;
            if (got === s.v) n_pass++;
            else $display("FAIL step%0d outputs got=%b exp=%b", s.id, got, s.v);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t I0, FA, FW, FLT, D0;
        I0  = mk(3'd0, 0,0,0,0,0,0,0, 2'b00, 3'b000, 0,0);
        FA  = mk(3'd1, 1,0,0,1,1,0,0, 2'b00, 3'b000, 0,0);
        FW  = mk(3'd1, 1,0,0,0,0,0,0, 2'b00, 3'b000, 0,0);
        FLT = mk(3'd7, 0,0,0,0,0,0,0, 2'b00, 3'b000, 0,1);
        D0  = mk(3'd2, 0,0,0,0,0,0,0, 2'b00, 3'b000, 0,0);

        repeat (2) @(posedge clk);
        #1;
        step(0, 1, 4'b0000, 0, 1, I0);
        step(1, 0, 4'b0000, 0, 0, I0);
        step(1, 1, 4'b0000, 0, 0, I0);
        // LOADI, zero-wait, garbage opcode during FETCH
        step(1, 1, 4'b1101, 0, 1, FA);
        step(1, 1, 4'b0100, 0, 0, D0);
        step(1, 1, 4'b0100, 0, 0, mk(3'd4, 0,0,0,0,0,0,1, 2'b01, 3'b000, 1,0));
        // SUB, ack in DECODE ignored, two MEM wait cycles
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b1001, 0, 1, mk(3'd2, 0,0,0,0,0,0,0, 2'b00, 3'b001, 0,0));
        step(1, 1, 4'b1001, 0, 0, mk(3'd3, 1,0,1,0,0,0,0, 2'b00, 3'b001, 0,0));
        step(1, 1, 4'b1001, 0, 0, mk(3'd3, 1,0,1,0,0,0,0, 2'b00, 3'b001, 0,0));
        step(1, 1, 4'b1001, 0, 1, mk(3'd3, 1,0,1,0,0,0,1, 2'b10, 3'b001, 1,0));
        // BZ taken then not taken
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b1111, 1, 0, mk(3'd2, 0,0,0,0,0,0,0, 2'b00, 3'b111, 0,0));
        step(1, 1, 4'b1111, 1, 0, mk(3'd4, 0,0,0,0,0,1,0, 2'b00, 3'b111, 1,0));
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b1111, 0, 0, mk(3'd2, 0,0,0,0,0,0,0, 2'b00, 3'b111, 0,0));
        step(1, 1, 4'b1111, 0, 0, mk(3'd4, 0,0,0,0,0,0,0, 2'b00, 3'b111, 1,0));
        // JUMP with one FETCH wait cycle
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b0001, 0, 0, D0);
        step(1, 1, 4'b0001, 0, 0, mk(3'd4, 0,0,0,0,0,1,0, 2'b00, 3'b000, 1,0));
        // SLL
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b0101, 0, 0, D0);
        step(1, 1, 4'b0101, 0, 0, mk(3'd4, 0,0,0,0,0,0,1, 2'b11, 3'b000, 1,0));
        // SAVE, run dropped during MEM: back to IDLE and stays
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b0010, 0, 0, D0);
        step(1, 0, 4'b0010, 0, 0, mk(3'd3, 1,1,1,0,0,0,0, 2'b00, 3'b000, 0,0));
        step(1, 0, 4'b0010, 0, 1, mk(3'd3, 1,1,1,0,0,0,0, 2'b00, 3'b000, 1,0));
        step(1, 0, 4'b1000, 0, 1, I0);
        step(1, 0, 4'b0011, 1, 1, I0);
        // Watchdog: four FETCH cycles without ack, then sticky FAULT
        step(1, 1, 4'b0000, 0, 0, I0);
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 0, 4'b0000, 0, 1, FLT);
        step(1, 1, 4'b0000, 0, 1, FLT);
        step(1, 0, 4'b0100, 0, 0, FLT);
        // Asynchronous reset clears fault within the same cycle
        step(0, 1, 4'b0000, 0, 0, I0);
        step(1, 1, 4'b0000, 0, 0, I0);
        // Ack on the fourth waiting cycle is accepted; undefined opcode faults
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 0, FW);
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b1101, 0, 0, mk(3'd2, 0,0,0,0,0,0,0, 2'b00, 3'b101, 0,0));
        step(1, 1, 4'b1101, 0, 0, FLT);
        // Reset, LOAD completes, NOP with run low
        step(0, 1, 4'b0000, 0, 0, I0);
        step(1, 1, 4'b0000, 0, 0, I0);
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b0011, 0, 0, D0);
        step(1, 1, 4'b0011, 0, 1, mk(3'd3, 1,0,1,0,0,0,1, 2'b00, 3'b000, 1,0));
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b0000, 0, 0, D0);
        step(1, 0, 4'b0000, 0, 0, mk(3'd4, 0,0,0,0,0,0,0, 2'b00, 3'b000, 1,0));
        step(1, 1, 4'b0000, 0, 0, I0);
        // LOAD interrupted by reset mid-MEM: mem_req drops in the same cycle
        step(1, 1, 4'b0000, 0, 1, FA);
        step(1, 1, 4'b0011, 0, 0, D0);
        step(1, 1, 4'b0011, 0, 0, mk(3'd3, 1,0,1,0,0,0,0, 2'b00, 3'b000, 0,0));
        step(0, 1, 4'b0011, 0, 1, I0);
        step(1, 0, 4'b0000, 0, 0, I0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
